pipelined_shifter: RTL
======================

// Module: pipelined_shifter
// PURPOSE
//  Parametrised, fully pipelined barrel shifter supporting logical left, logical right,
//  arithmetic right and rotate-left modes. It has a valid/ready stream interface with
//  backpressure and a pass-through tag. It sits beside the ALU and serves multi-cycle
//  shift ops, freeing the single-cycle datapath from the log2(WIDTH) mux chain.
// PARAMETERS
//  WIDTH    32               data width; power of two, >= 4
//  SHAMT_W  $clog2(WIDTH)    shift-amount width; equals number of pipeline stages
//  TAG_W    5                width of opaque tag (e.g. dest reg) carried with each op
// PORTS
//  clock      in   1        rising-edge clock
//  reset      in   1        synchronous, active-high reset
//  in_valid   in   1        input op present
//  in_ready   out  1        block can accept op this cycle
//  in_data    in   WIDTH    operand
//  in_shamt   in   SHAMT_W  shift amount, 0..WIDTH-1
//  in_mode    in   2        00 SLL, 01 SRL, 10 SRA, 11 ROL
//  in_tag     in   TAG_W    tag, returned unchanged with result
//  out_valid  out  1        result present
//  out_ready  in   1        consumer accepts result this cycle
//  out_data   out  WIDTH    shifted result
//  out_tag    out  TAG_W    tag of op producing out_data
//  busy       out  1        any stage holds a valid op
// BEHAVIOUR
//  - Stage k (k = 0..SHAMT_W-1) shifts by 2^(SHAMT_W-1-k) when its shamt bit is set,
//    largest first. Each stage registers data, remaining shamt bits, mode, tag and valid.
//  - Shift rules: SLL fills with 0; SRL fills with 0; SRA fills with the operand MSB,
//    captured at input and carried down the pipe; ROL moves the bits shifted out at the
//    top back in at the bottom.
//  - Global stall: adv = ~out_valid | out_ready; in_ready = adv (combinational).
//    No per-stage bubble collapsing.
//  - On adv, every stage loads from its predecessor. Stage 0 loads
//    (in_valid & in_ready) as its valid bit.
//  - On ~adv, all stage registers hold; out_data and out_tag stay stable while
//    out_valid=1 and out_ready=0.
//  - Latency: exactly SHAMT_W cycles from accept edge to out_valid, absent stalls
//    (5 for WIDTH=32). Throughput: 1 op/cycle.
//  - Output is the last stage register; out_valid is the last stage valid bit.
//  - Ops complete in issue order; the tag is never modified.
//  - in_valid=1 with in_ready=0: the op is not taken; the source must hold it
//    (standard valid/ready).
//  - busy = OR of all stage valid bits.
//  - shamt=0 in every mode: out_data = in_data. SRA on a positive operand equals SRL.
//  - Reset: all valid bits, data, shamt, mode and tag registers go to 0 on the next edge.
//    out_valid=0, out_data=0, out_tag=0, busy=0, in_ready=1. In-flight ops are discarded
//    with no output. Reset overrides a simultaneous accept.
//  - Inputs are ignored while reset=1.
// TESTING (WIDTH=32, TAG_W=5)
//  - SLL 0x00000001 by 31, tag 3, out_ready=1 -> 5 cycles later out_valid=1,
//    out_data=0x80000000, out_tag=3.
//  - 0x80000000 by 4: SRA -> 0xF8000000; SRL -> 0x08000000.
//    ROL 0x80000001 by 1 -> 0x00000003.
//  - shamt=0 in each of 4 modes with 0xDEADBEEF -> 0xDEADBEEF each.
//  - 8 back-to-back ops, tags 0..7, out_ready low 3 cycles mid-stream -> in_ready low
//    those cycles, out_data held, all 8 results in order, no loss or duplication.
//  - Pipe full (5 ops in flight), reset pulsed 1 cycle -> next cycle out_valid=0,
//    busy=0, in_ready=1; no stale result ever appears.
//  - Random 10k ops in all modes with random backpressure vs. Verilog <<, >>, >>>,
//    rotate model -> zero mismatches.

Source files
------------

// File: rtl/pipelined_shifter.sv
// pipelined_shifter: SHAMT_W-stage barrel shifter (SLL/SRL/SRA/ROL) behind a
// valid/ready stream with a single global stall and an opaque pass-through tag.
module pipelined_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int TAG_W   = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_mode,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag,
  output logic               busy
);

  localparam int N = SHAMT_W;

  // Stage j keeps only the N-1-j shamt bits still to be consumed; they are
  // packed back to back into one vector, this gives each stage's offset.
  function automatic int shamt_off(input int j);
    int s;
    s = 0;
    for (int i = 0; i < j; i++) s += N - 1 - i;
    return s;
  endfunction

  localparam int SH_BITS = shamt_off(N - 1);

  logic [N-1:0][WIDTH-1:0] data_q, data_d;
  logic [N-1:0][TAG_W-1:0] tag_q, tag_d;
  logic [N-1:0]            valid_q, valid_d;
  logic [N-2:0][1:0]       mode_q, mode_d;
  logic [N-2:0]            sign_q, sign_d;
  logic [SH_BITS-1:0]      shamt_q, shamt_d;
  logic                    adv;

  assign adv       = ~valid_q[N-1] | out_ready;
  assign in_ready  = adv;
  assign out_valid = valid_q[N-1];
  assign out_data  = data_q[N-1];
  assign out_tag   = tag_q[N-1];
  assign busy      = |valid_q;

  for (genvar k = 0; k < N; k++) begin : g_stage
    localparam int AMT     = 1 << (N - 1 - k);
    localparam int OFF_IN  = shamt_off(k - 1);
    localparam int OFF_OUT = shamt_off(k);

    logic [WIDTH-1:0] src_data;
    logic [N-1-k:0]   src_shamt;
    logic [1:0]       src_mode;
    logic             src_sign;
    logic [WIDTH-1:0] shifted;

    if (k == 0) begin : g_head
      assign src_data   = in_data;
      assign src_shamt  = in_shamt;
      assign src_mode   = in_mode;
      assign src_sign   = in_data[WIDTH-1];
      assign tag_d[k]   = in_tag;
      assign valid_d[k] = in_valid & adv;
    end else begin : g_body
      assign src_data   = data_q[k-1];
      assign src_shamt  = shamt_q[OFF_IN +: N-k];
      assign src_mode   = mode_q[k-1];
      assign src_sign   = sign_q[k-1];
      assign tag_d[k]   = tag_q[k-1];
      assign valid_d[k] = valid_q[k-1];
    end

    // SRA fills from the sign captured at entry, not from the partially
    // shifted word, so every stage sees the original operand MSB.
    always_comb begin
      shifted = src_data;
      if (src_shamt[N-1-k]) begin
        case (src_mode)
          2'b00:   shifted = src_data << AMT;
          2'b01:   shifted = src_data >> AMT;
          2'b10:   shifted = (src_data >> AMT) | ({WIDTH{src_sign}} << (WIDTH - AMT));
          default: shifted = (src_data << AMT) | (src_data >> (WIDTH - AMT));
        endcase
      end
    end

    assign data_d[k] = shifted;

    if (k < N - 1) begin : g_side
      assign shamt_d[OFF_OUT +: N-1-k] = src_shamt[N-2-k:0];
      assign mode_d[k]                 = src_mode;
      assign sign_d[k]                 = src_sign;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      data_q  <= '0;
      tag_q   <= '0;
      valid_q <= '0;
      mode_q  <= '0;
      sign_q  <= '0;
      shamt_q <= '0;
    end else if (adv) begin
      data_q  <= data_d;
      tag_q   <= tag_d;
      valid_q <= valid_d;
      mode_q  <= mode_d;
      sign_q  <= sign_d;
      shamt_q <= shamt_d;
    end
  end

endmodule
